// File: rtl/l2k_msched_mc.sv
// l2k_msched_mc: round-robin multi-client scheduler feeding an in-order RAM command FIFO.
// Define L2K_MSCHED_FLUSH_EN to let flush discard queued, not-yet-dequeued reads.
module l2k_msched_mc #(
    parameter int NUM_CLIENTS = 2,
    parameter int QUEUE_DEPTH = 8,
    parameter int ADDR_W      = 32,
    parameter int CID_W       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [NUM_CLIENTS-1:0]        req_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*32-1:0]     req_wdata,
    input  logic [NUM_CLIENTS*2-1:0]      req_size,
    output logic                          rsp_valid,
    output logic [CID_W-1:0]              rsp_client,
    output logic [ADDR_W-1:0]             rsp_addr,
    output logic [31:0]                   rsp_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [31:0]                   ram_data_out,
    input  logic [31:0]                   ram_data_in,
    output logic                          ram_we,
    output logic                          ram_ce,
    input  logic                          ram_rdy,
    output logic                          full,
    output logic [$clog2(QUEUE_DEPTH):0]  count,
    input  logic                          flush
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [CID_W-1:0]  cid;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR} state_t;

    cmd_t             mem   [QUEUE_DEPTH];
    cmd_t             mem_n [QUEUE_DEPTH];
    cmd_t             new_cmd;
    cmd_t             hd;
    logic [PW-1:0]    head, tail, head_n, tail_n;
    logic [CW-1:0]    count_n;
    logic [CID_W-1:0] ptr, gnt;
    logic             gnt_vld, enq, deq;
    state_t           state, state_n;
    logic             ce_n, we_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]       cur_size;
    logic [CID_W-1:0] cur_cid;

    function automatic logic [31:0] lane_get(input logic [31:0] w,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  a);
        unique case (1'b1)
            sz == 2'd0: lane_get = {24'd0, 8'(w >> {a, 3'b000})};
            sz == 2'd1: lane_get = {16'd0, 16'(w >> {a[1], 4'b0000})};
            default:    lane_get = w;
        endcase
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  a,
                                             input logic [15:0] d);
        logic [31:0] m, v;
        if (sz == 2'd0) begin
            m = 32'h0000_00ff << {a, 3'b000};
            v = {24'd0, d[7:0]} << {a, 3'b000};
        end else begin
            m = 32'h0000_ffff << {a[1], 4'b0000};
            v = {16'd0, d} << {a[1], 4'b0000};
        end
        lane_put = (w & ~m) | v;
    endfunction

    // ptr holds the client with highest priority this cycle
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            for (int j = 0; j < NUM_CLIENTS; j++) begin
                if (req_valid[j] && ((int'(ptr) + i) % NUM_CLIENTS == j)) begin
                    gnt     = CID_W'(j);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign enq = gnt_vld && !full;
    assign deq = (state == IDLE) && (count != '0);
    assign hd  = mem[head];

    always_comb begin
        req_ready = '0;
        new_cmd   = '0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            if (gnt == CID_W'(j)) begin
                req_ready[j]  = enq;
                new_cmd.wr    = req_write[j];
                new_cmd.size  = req_size[2*j +: 2];
                new_cmd.cid   = CID_W'(j);
                new_cmd.addr  = req_addr[ADDR_W*j +: ADDR_W];
                new_cmd.wdata = req_wdata[32*j +: 32];
            end
        end
    end

`ifdef L2K_MSCHED_FLUSH_EN
    logic [CW-1:0] k, live;
    logic [PW-1:0] src;
`else
    logic unused_flush;
    assign unused_flush = flush;
`endif

    always_comb begin
        mem_n   = mem;
        head_n  = head;
        tail_n  = tail;
        if (enq) begin
            mem_n[tail] = new_cmd;
            tail_n      = tail + PW'(1);
        end
        if (deq)
            head_n = head + PW'(1);
        count_n = count + CW'(enq) - CW'(deq);
`ifdef L2K_MSCHED_FLUSH_EN
        k    = '0;
        src  = '0;
        live = count - CW'(deq);
        // compact surviving writes towards the head, preserving their order
        if (flush) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                src = head_n + PW'(i);
                if ((CW'(i) < live) && mem[src].wr) begin
                    mem_n[head_n + k[PW-1:0]] = mem[src];
                    k = k + CW'(1);
                end
            end
            if (enq && new_cmd.wr) begin
                mem_n[head_n + k[PW-1:0]] = new_cmd;
                k = k + CW'(1);
            end
            tail_n  = head_n + k[PW-1:0];
            count_n = k;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            ptr   <= '0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
            full  <= (count_n == CW'(QUEUE_DEPTH));
            if (enq)
                ptr <= (gnt == CID_W'(NUM_CLIENTS - 1)) ? '0 : gnt + CID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem <= mem_n;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (deq) begin
                    if (!hd.wr)           state_n = RD;
                    else if (hd.size[1])  state_n = WR;
                    else                  state_n = RMW_RD;
                end
            end
            RMW_RD:         if (ram_rdy) state_n = RMW_WR;
            RD, RMW_WR, WR: if (ram_rdy) state_n = IDLE;
            default:        state_n = IDLE;
        endcase
    end

    always_comb begin
        ce_n = (state_n != IDLE);
        we_n = (state_n == RMW_WR) || (state_n == WR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_client   <= '0;
            rsp_addr     <= '0;
            rsp_data     <= '0;
            cur_addr     <= '0;
            cur_size     <= '0;
            cur_cid      <= '0;
        end else begin
            ram_ce    <= ce_n;
            ram_we    <= we_n;
            rsp_valid <= 1'b0;
            if (deq) begin
                cur_addr     <= hd.addr;
                cur_size     <= hd.size;
                cur_cid      <= hd.cid;
                ram_addr     <= {hd.addr[ADDR_W-1:2], 2'b00};
                ram_data_out <= hd.wdata;
            end
            // ram_data_out still holds the store data until the merge replaces it
            if (state == RMW_RD && ram_rdy)
                ram_data_out <= lane_put(ram_data_in, cur_size, cur_addr[1:0],
                                         ram_data_out[15:0]);
            if (state == RD && ram_rdy) begin
                rsp_valid  <= 1'b1;
                rsp_client <= cur_cid;
                rsp_addr   <= cur_addr;
                rsp_data   <= lane_get(ram_data_in, cur_size, cur_addr[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_l2k_msched_mc.sv
// tb_l2k_msched_mc: vector table plus multi-cycle sequences for l2k_msched_mc.
// Read responses are checked against a scoreboard queue filled at issue time.
module tb_l2k_msched_mc;
    localparam int N  = 2;
    localparam int D  = 8;
    localparam int AW = 32;
    localparam int CI = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid, req_ready, req_write;
    logic [N*AW-1:0]     req_addr;
    logic [N*32-1:0]     req_wdata;
    logic [N*2-1:0]      req_size;
    logic                rsp_valid;
    logic [CI-1:0]       rsp_client;
    logic [AW-1:0]       rsp_addr;
    logic [31:0]         rsp_data;
    logic [AW-1:0]       ram_addr;
    logic [31:0]         ram_data_out, ram_data_in;
    logic                ram_we, ram_ce, ram_rdy;
    logic                full;
    logic [$clog2(D):0]  count;
    logic                flush;

    logic [31:0] ram [0:1023];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CI-1:0] cid;
        logic [31:0]   addr;
        logic [31:0]   data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        int          cid;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[14];

    l2k_msched_mc #(.NUM_CLIENTS(N), .QUEUE_DEPTH(D), .ADDR_W(AW), .CID_W(CI)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_client(rsp_client), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_we(ram_we), .ram_ce(ram_ce), .ram_rdy(ram_rdy),
        .full(full), .count(count), .flush(flush)
    );

    always #5 clk = ~clk;

    assign ram_data_in = ram[ram_addr[11:2]];
    always @(posedge clk)
        if (ram_ce && ram_rdy && ram_we) ram[ram_addr[11:2]] = ram_data_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got addr %h expected no response", rsp_addr);
            end else begin
                e = sb.pop_front();
                chk("rsp_client", 32'(rsp_client), 32'(e.cid));
                chk("rsp_addr", rsp_addr, e.addr);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic expect_rsp(input int c, input logic [31:0] a, input logic [31:0] d);
        rsp_t e;
        e.cid  = CI'(c);
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic send(input int c, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_write[c]           = wr;
        req_size[2*c +: 2]     = sz;
        req_addr[AW*c +: AW]   = a;
        req_wdata[32*c +: 32]  = wd;
        req_valid[c]           = 1'b1;
        n = 0;
        #1;
        while (!req_ready[c] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", 32'(req_ready[c]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((count != 0 || ram_ce) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: got busy after 200 cycles expected idle", name);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, extra, lat;
        logic [N-1:0] g;

        tbl[0]  = '{0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1]  = '{0, 1'b0, 2'd2, 32'h100, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 2'd0, 32'h202, 32'h000000AA, 32'h11AA3344};
        tbl[3]  = '{1, 1'b0, 2'd0, 32'h202, 32'h0,        32'h000000AA};
        tbl[4]  = '{0, 1'b1, 2'd1, 32'h206, 32'h0000BEEF, 32'hBEEF0000};
        tbl[5]  = '{1, 1'b0, 2'd1, 32'h207, 32'h0,        32'h0000BEEF};
        tbl[6]  = '{1, 1'b0, 2'd0, 32'h203, 32'h0,        32'h00000011};
        tbl[7]  = '{0, 1'b0, 2'd3, 32'h200, 32'h0,        32'h11AA3344};
        tbl[8]  = '{1, 1'b1, 2'd1, 32'h200, 32'h12345678, 32'h11AA5678};
        tbl[9]  = '{0, 1'b0, 2'd0, 32'h201, 32'h0,        32'h00000056};
        tbl[10] = '{0, 1'b1, 2'd0, 32'h105, 32'hCCCCCC5A, 32'h00005A00};
        tbl[11] = '{1, 1'b0, 2'd2, 32'h104, 32'h0,        32'h00005A00};
        tbl[12] = '{0, 1'b0, 2'd1, 32'h100, 32'h0,        32'h0000BEEF};
        tbl[13] = '{1, 1'b1, 2'd3, 32'h108, 32'hCAFEF00D, 32'hCAFEF00D};

        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[32'h200 >> 2] = 32'h11223344;
        rst = 1'b1;
        flush = 1'b0;
        ram_rdy = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        req_size = '0;
        repeat (3) @(negedge clk);
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_data_out", ram_data_out, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (!tbl[i].wr) expect_rsp(tbl[i].cid, tbl[i].addr, tbl[i].exp);
            send(tbl[i].cid, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wdata);
            wait_idle("vec_idle");
            if (tbl[i].wr)
                chk($sformatf("vec%0d_ram", i), ram[tbl[i].addr[11:2]], tbl[i].exp);
        end

        expect_rsp(1, 32'h108, 32'hCAFEF00D);
        send(1, 1'b0, 2'd2, 32'h108, 32'h0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        wait_idle("lat_idle");

        do_reset();
        ram_rdy = 1'b0;
        req_write = '1;
        req_size = {2'd2, 2'd2};
        req_addr = {32'h304, 32'h300};
        a = 0;
        req_wdata = {32'(a), 32'(a)};
        req_valid = '1;
        for (int cy = 0; cy < 12; cy++) begin
            #1;
            if (a < D + 1) begin
                chk("rr_grant", 32'(req_ready), 32'(1 << (a % 2)));
                chk("rr_not_full", 32'(full), 32'd0);
            end else begin
                chk("full_ready", 32'(req_ready), 32'd0);
                chk("full_flag", 32'(full), 32'd1);
                chk("full_count", 32'(count), 32'(D));
            end
            if (req_ready != '0) a++;
            @(negedge clk);
            req_wdata = {32'(a), 32'(a)};
        end
        ram_rdy = 1'b1;
        @(negedge clk);
        ram_rdy = 1'b0;
        extra = 0;
        g = '0;
        for (int cy = 0; cy < 6; cy++) begin
            #1;
            if (req_ready != '0) begin
                extra++;
                g = req_ready;
            end
            @(negedge clk);
        end
        #1;
        chk("free_one_accepts", 32'(extra), 32'd1);
        chk("free_one_client", 32'(g), 32'd2);
        chk("refull_flag", 32'(full), 32'd1);
        chk("refull_count", 32'(count), 32'(D));
        req_valid = '0;
        ram_rdy = 1'b1;
        wait_idle("drain_idle");
        chk("drain_ram_c0", ram[32'h300 >> 2], 32'd8);
        chk("drain_ram_c1", ram[32'h304 >> 2], 32'd9);

        ram[32'h400 >> 2] = 32'h55667788;
        ram_rdy = 1'b0;
        send(0, 1'b1, 2'd0, 32'h401, 32'h99);
        send(0, 1'b1, 2'd2, 32'h408, 32'h1234);
        @(negedge clk);
        chk("rmw_rd_ce", 32'(ram_ce), 32'd1);
        chk("rmw_rd_we", 32'(ram_we), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_ce", 32'(ram_ce), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ram_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_ram", ram[32'h400 >> 2], 32'h55667788);
        chk("rst_mid_ram2", ram[32'h408 >> 2], 32'h0);

        ram_rdy = 1'b0;
        send(0, 1'b1, 2'd2, 32'h500, 32'h5);
`ifdef L2K_MSCHED_FLUSH_EN
        send(0, 1'b0, 2'd2, 32'h10, 32'h0);
        send(0, 1'b1, 2'd2, 32'h14, 32'h77);
        send(1, 1'b0, 2'd2, 32'h18, 32'h0);
        @(negedge clk);
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("post_flush_count", 32'(count), 32'd1);
        ram_rdy = 1'b1;
        wait_idle("flush_idle");
        chk("flush_kept_write", ram[32'h14 >> 2], 32'h77);
`else
        expect_rsp(0, 32'h100, 32'hDEADBEEF);
        send(0, 1'b0, 2'd2, 32'h100, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ignored_count", 32'(count), 32'd1);
        ram_rdy = 1'b1;
        wait_idle("flush_idle");
`endif
        chk("busy_write_ram", ram[32'h500 >> 2], 32'h5);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
